instruction_fetch: RTL

- Pipeline stage directly upstream of instruction decode.
- Owns the PC, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and presents {pc, instruction} to decode through a registered valid/ready output slot.
- Accepts redirects (taken branch / jump) from execute; squashes wrong-path fetches, including a response already in flight.

---
 rtl/argon_pkg.sv | 13 +
 rtl/instruction_fetch.sv | 131 +++++++++++++
 2 files changed

// File: rtl/argon_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the instruction fetch stage.
package argon_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches words from imem,
// and hands {pc, instruction} to decode through a one-entry slot.
module instruction_fetch
  import argon_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] INSTR_NOP = argon_pkg::INSTR_NOP
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_drop;
  logic        r_valid;
  logic [31:0] r_opc;
  logic [31:0] r_instr;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic        w_drop_nxt;
  logic        w_valid_nxt;
  logic [31:0] w_opc_nxt;
  logic [31:0] w_instr_nxt;

  logic        w_consume;
  logic        w_req;
  logic        w_fire;
  logic        w_fill;
  logic [31:0] w_tgt;
  logic        w_unused;

  assign w_tgt    = {i_redirect_pc[31:2], 2'b00};
  assign w_unused = ^i_redirect_pc[1:0];

  assign w_consume = r_valid & i_ready;
  assign w_req     = i_rst_n & (r_state == S_REQ)
                   & (~r_valid | i_ready);
  assign w_fire    = w_req & i_imem_gnt;
  assign w_fill    = (r_state == S_WAIT) & i_imem_rvalid
                   & ~r_drop & ~i_redirect;

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_valid       = r_valid;
  assign o_pc          = r_opc;
  assign o_instruction = r_instr;

  // Next-state, PC mux and output slot update; redirect wins everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_fetch_pc_nxt = r_fetch_pc;
    w_drop_nxt     = r_drop;
    w_valid_nxt    = r_valid;
    w_opc_nxt      = r_opc;
    w_instr_nxt    = r_instr;

    unique case (r_state)
      S_REQ: begin
        if (w_fire) begin
          w_fetch_pc_nxt = r_pc;
          w_pc_nxt       = r_pc + 32'(INSTR_BYTES);
          w_state_nxt    = S_WAIT;
          w_drop_nxt     = i_redirect;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          w_state_nxt = S_REQ;
          w_drop_nxt  = 1'b0;
        end else if (i_redirect) begin
          w_drop_nxt = 1'b1;
        end
      end
    endcase

    if (i_redirect) begin
      w_pc_nxt = w_tgt;
    end

    if (i_redirect) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = INSTR_NOP;
    end else if (w_fill) begin
      w_valid_nxt = 1'b1;
      w_opc_nxt   = r_fetch_pc;
      w_instr_nxt = i_imem_rdata;
    end else if (w_consume) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = INSTR_NOP;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= {RESET_PC[31:2], 2'b00};
      r_fetch_pc <= '0;
      r_drop     <= 1'b0;
      r_valid    <= 1'b0;
      r_opc      <= '0;
      r_instr    <= INSTR_NOP;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_valid    <= w_valid_nxt;
      r_opc      <= w_opc_nxt;
      r_instr    <= w_instr_nxt;
    end
  end

endmodule
